mem_stage_controller: RTL and testbench

Sequences the MEM-stage data memory access of the ARM pipeline against an external 16-bit asynchronous SRAM. Sits between the EXE/MEM pipeline register outputs (read/write enables, ALU address, Rm store data) and the SRAM pins. Splits each 32-bit access into two half-word phases with programmable wait states. Drops `ready` to freeze the pipeline registers and hazard logic until the access completes.

---
 rtl/arm_mem_pkg.sv | 25 ++
 rtl/sram_phase_counter.sv | 37 +++
 rtl/mem_stage_controller.sv | 140 ++++++++++++++
 tb/tb_mem_stage_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM access path.
// Word-index helper maps a byte address onto the data-memory SRAM.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } mem_state_t;

  localparam int SRAM_AW       = 18;
  localparam int SRAM_DW       = 16;
  localparam int DATA_MEM_BASE = 1024;

  function automatic logic [16:0] word_idx(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    logic [31:0] off;
    off = addr - base;
    return off[18:2];
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Wait-state counter for one half-word SRAM phase.
// Clear wins over enable; last flags the hold cycle.
module sram_phase_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage sequencer: one 32-bit access as two 16-bit SRAM phases.
// Freezes the pipeline via ready until the DONE cycle.
module mem_stage_controller
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = DATA_MEM_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [31:0] BASE = 32'(ADDR_BASE);

  mem_state_t         state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               op_wr_q, op_wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0] dq_o_q, dq_o_d;

  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_last;
  logic [3:0] cnt;
  logic       req;
  logic       busy;

  assign req = rd_en | wr_en;

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .last(cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_wr_d     = op_wr_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          addr_d      = address;
          wdata_d     = write_data;
          op_wr_d     = wr_en;
          sram_addr_d = {word_idx(address, BASE), 1'b0};
          if (wr_en) begin
            dq_o_d = write_data[15:0];
          end
          state_d = LO;
        end
      end
      LO: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          cnt_clr     = 1'b1;
          state_d     = HI;
          sram_addr_d = {word_idx(addr_q, BASE), 1'b1};
          if (op_wr_q) begin
            dq_o_d = wdata_q[31:16];
          end else begin
            rdata_d[15:0] = sram_dq_i;
          end
        end
      end
      HI: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          cnt_clr = 1'b1;
          state_d = DONE;
          if (!op_wr_q) begin
            rdata_d[31:16] = sram_dq_i;
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_wr_q     <= 1'b0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
    end
  end

  // Last cycle of each phase keeps address/data stable with strobe high.
  assign busy       = (state_q == LO) | (state_q == HI);
  assign sram_dq_oe = op_wr_q & busy;
  assign sram_we_n  = ~(op_wr_q & busy & ~cnt_last);
  assign ready      = ~req | (state_q == DONE);
  assign read_data  = rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;

  logic unused_ok;
  assign unused_ok = ^cnt;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed bench for mem_stage_controller with W=2 and W=4 instances.
// Each instance drives its own behavioural 16-bit SRAM.
module tb_mem_stage_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
  logic [31:0] addr_a = 0, wd_a = 0, addr_b = 0, wd_b = 0;
  logic [31:0] rdat_a, rdat_b;
  logic        ready_a, ready_b;
  logic [17:0] sa_a, sa_b;
  logic [15:0] dqo_a, dqo_b, dqi_a, dqi_b;
  logic        oe_a, oe_b, we_n_a, we_n_b;

  mem_stage_controller #(.WAIT_CYCLES(2), .ADDR_BASE(1024)) u_a (
    .clk(clk), .rst(rst), .rd_en(rd_a), .wr_en(wr_a),
    .address(addr_a), .write_data(wd_a), .read_data(rdat_a),
    .ready(ready_a), .sram_addr(sa_a), .sram_dq_o(dqo_a),
    .sram_dq_i(dqi_a), .sram_dq_oe(oe_a), .sram_we_n(we_n_a)
  );

  mem_stage_controller #(.WAIT_CYCLES(4), .ADDR_BASE(1024)) u_b (
    .clk(clk), .rst(rst), .rd_en(rd_b), .wr_en(wr_b),
    .address(addr_b), .write_data(wd_b), .read_data(rdat_b),
    .ready(ready_b), .sram_addr(sa_b), .sram_dq_o(dqo_b),
    .sram_dq_i(dqi_b), .sram_dq_oe(oe_b), .sram_we_n(we_n_b)
  );

  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];
  logic        pl_en = 0, pl_sel = 0;
  logic [5:0]  pl_idx = 0;
  logic [15:0] pl_dat = 0;

  assign dqi_a = mem_a[sa_a[5:0]];
  assign dqi_b = mem_b[sa_b[5:0]];

  always @(posedge clk) begin
    if (pl_en && !pl_sel) mem_a[pl_idx] <= pl_dat;
    else if (!we_n_a && oe_a) mem_a[sa_a[5:0]] <= dqo_a;
    if (pl_en && pl_sel) mem_b[pl_idx] <= pl_dat;
    else if (!we_n_b && oe_b) mem_b[sa_b[5:0]] <= dqo_b;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [5:0] idx,
                         input logic [15:0] dat);
    @(negedge clk);
    pl_sel = sel; pl_idx = idx; pl_dat = dat; pl_en = 1;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
  endtask

  // Presents a request in cycle 0 and follows it until ready rises.
  task automatic run(input logic sel, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     output int rcyc, output int we_lo,
                     output int oe_cnt, output logic [31:0] rdata);
    logic done;
    logic rdy, wn, oe;
    @(negedge clk);
    if (sel) begin rd_b = r; wr_b = w; addr_b = a; wd_b = d; end
    else begin rd_a = r; wr_a = w; addr_a = a; wd_a = d; end
    rcyc = 0; we_lo = 0; oe_cnt = 0; rdata = '0; done = 0;
    while (!done && rcyc < 40) begin
      #1;
      rdy = sel ? ready_b : ready_a;
      wn  = sel ? we_n_b : we_n_a;
      oe  = sel ? oe_b : oe_a;
      if (!wn) we_lo++;
      if (oe) oe_cnt++;
      if (rdy) begin
        done = 1;
        rdata = sel ? rdat_b : rdat_a;
      end else begin
        @(negedge clk);
        rcyc++;
      end
    end
  endtask

  int rc, wl, oc, ok;
  logic [31:0] rd;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_ready", {31'b0, ready_a}, 1);
    chk("rst_we_n", {31'b0, we_n_a}, 1);
    chk("rst_oe", {31'b0, oe_a}, 0);
    chk("rst_rdata", rdat_a, 0);
    chk("rst_saddr", {14'b0, sa_a}, 0);
    chk("rst_dq_o", {16'b0, dqo_a}, 0);

    run(0, 0, 1, 32'd1024, 32'hDEADBEEF, rc, wl, oc, rd);
    go_idle();
    chk("wr_ready_cyc", rc, 5);
    chk("wr_we_low", wl, 2);
    chk("wr_oe_cnt", oc, 4);
    chk("wr_hw0", {16'b0, mem_a[0]}, 32'h0000BEEF);
    chk("wr_hw1", {16'b0, mem_a[1]}, 32'h0000DEAD);

    preload(0, 2, 16'h1234);
    preload(0, 3, 16'hABCD);
    run(0, 1, 0, 32'd1028, 32'h0, rc, wl, oc, rd);
    go_idle();
    chk("rd_data", rd, 32'hABCD1234);
    chk("rd_oe_cnt", oc, 0);
    chk("rd_we_low", wl, 0);
    chk("rd_ready_cyc", rc, 5);

    preload(0, 5, 16'h5555);
    run(0, 1, 1, 32'd1032, 32'h0000FFFF, rc, wl, oc, rd);
    go_idle();
    chk("both_hw4", {16'b0, mem_a[4]}, 32'h0000FFFF);
    chk("both_hw5", {16'b0, mem_a[5]}, 32'h00000000);
    chk("both_rd_keep", rdat_a, 32'hABCD1234);

    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (ready_a && we_n_a && !oe_a) ok++;
    end
    chk("idle_10", ok, 10);

    run(0, 0, 1, 32'd1040, 32'h13579BDF, rc, wl, oc, rd);
    run(0, 1, 0, 32'd1040, 32'h0, rc, wl, oc, rd);
    go_idle();
    chk("b2b_data", rd, 32'h13579BDF);
    chk("b2b_ready_cyc", rc, 5);

    preload(0, 12, 16'h1111);
    preload(0, 13, 16'h2222);
    @(negedge clk);
    wr_a = 1; addr_a = 32'd1048; wd_a = 32'hAAAABBBB;
    @(negedge clk);
    #1;
    chk("rst_mid_we_lo", {31'b0, we_n_a}, 0);
    @(negedge clk);
    rst = 1; wr_a = 0;
    @(negedge clk);
    #1;
    chk("rst_mid_we_n", {31'b0, we_n_a}, 1);
    chk("rst_mid_oe", {31'b0, oe_a}, 0);
    chk("rst_mid_ready", {31'b0, ready_a}, 1);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_hw12", {16'b0, mem_a[12]}, 32'h0000BBBB);
    chk("rst_mid_hw13", {16'b0, mem_a[13]}, 32'h00002222);

    preload(1, 0, 16'h5678);
    preload(1, 1, 16'h9ABC);
    run(1, 1, 0, 32'd1024, 32'h0, rc, wl, oc, rd);
    go_idle();
    chk("w4_ready_cyc", rc, 9);
    chk("w4_data", rd, 32'h9ABC5678);
    chk("w4_oe_cnt", oc, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
